// File: rtl/md_pkg.sv
// Shared types and helpers for the multi-driver write path.
package md_pkg;

    localparam int unsigned MD_AW     = 8;
    localparam int unsigned MD_STAT_W = 16;

    typedef logic [1:0]                     md_bank_t;
    typedef logic [3:0][MD_STAT_W-1:0]      md_stat_t;

    // Driver bank is carried in index bits [4:3].
    function automatic md_bank_t md_bank(input logic [MD_AW-1:0] ai);
        return ai[4:3];
    endfunction

endpackage

// File: rtl/md_io.sv
// Mux-to-buffer write strobe and index bundle.
interface md_io;
    import md_pkg::*;

    logic               we;
    logic [MD_AW-1:0]   ai;

    modport slave  (input  we, ai);
    modport master (output we, ai);

endinterface

// File: rtl/md_fifo.sv
// Storage, pointers and occupancy for the write-capture buffer.
module md_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                din,
    output logic [AW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/md_wbuf.sv
// Write-capture buffer: drop/ovf policy, handshake glue, optional per-bank stats.
// Define MD_WBUF_STAT_EN to build the accepted-write counters.
module md_wbuf
    import md_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = MD_AW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    md_io.slave                          md_if,
    output logic                         out_vld,
    output logic [AW-1:0]                out_ai,
    input  logic                         out_rdy,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output md_stat_t                     stat
);

    logic pop;
    logic acc;
    logic drop;

    assign out_vld = !empty;
    assign pop     = out_vld & out_rdy;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign acc     = md_if.we & (!full | pop);
    assign drop    = md_if.we & full & !pop;

    md_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (acc),
        .pop   (pop),
        .din   (md_if.ai),
        .dout  (out_ai),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

`ifdef MD_WBUF_STAT_EN
    md_bank_t bank;
    assign bank = md_bank(md_if.ai);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat <= '0;
        end else if (ovf_clr) begin
            stat <= '0;
        end else if (acc && stat[bank] != '1) begin
            stat[bank] <= stat[bank] + 1'b1;
        end
    end
`else
    assign stat = '0;
`endif

endmodule

// File: tb/tb_md_wbuf.sv
// Randomised, model-checked bench for md_wbuf.
module tb_md_wbuf;
    import md_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        out_vld;
    logic [7:0]  out_ai;
    logic        out_rdy;
    logic        full;
    logic        empty;
    logic [3:0]  cnt;
    logic        ovf;
    logic        ovf_clr;
    md_stat_t    stat;

    int checks = 0;
    int errors = 0;

    md_io u_io ();

    md_wbuf #(.DEPTH(8), .AW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .md_if   (u_io),
        .out_vld (out_vld),
        .out_ai  (out_ai),
        .out_rdy (out_rdy),
        .full    (full),
        .empty   (empty),
        .cnt     (cnt),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .stat    (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of indices, sticky flag, per-bank counters.
    logic [7:0]  mq [$];
    bit          m_ovf;
    logic [15:0] m_stat [4];

    function automatic md_stat_t exp_stat();
        md_stat_t s;
        for (int i = 0; i < 4; i++) s[i] = m_stat[i];
        return s;
    endfunction

    function automatic logic [7:0] exp_head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        for (int i = 0; i < 4; i++) m_stat[i] = 16'h0;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] a, input logic r, input logic c);
        bit p, f, ac, dr;
        p  = (mq.size() > 0) && r;
        f  = (mq.size() == 8);
        ac = w && (!f || p);
        dr = w && f && !p;
        if (p) void'(mq.pop_front());
        if (ac) mq.push_back(a);
        if (dr) m_ovf = 1;
        else if (c) m_ovf = 0;
`ifdef MD_WBUF_STAT_EN
        if (c) begin
            for (int i = 0; i < 4; i++) m_stat[i] = 16'h0;
        end else if (ac && m_stat[a[4:3]] != 16'hFFFF) begin
            m_stat[a[4:3]] = m_stat[a[4:3]] + 16'h1;
        end
`endif
    endtask

    task automatic step(input logic w, input logic [7:0] a, input logic r, input logic c);
        u_io.we = w;
        u_io.ai = a;
        out_rdy = r;
        ovf_clr = c;
        @(posedge clk);
        model_edge(w, a, r, c);
        #1;
    endtask

    task automatic test_reset();
        u_io.we = 0; u_io.ai = 0; out_rdy = 0; ovf_clr = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_vld, out_ai, full, empty, cnt, ovf} !== {1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b ai=%h full=%b empty=%b cnt=%0d ovf=%b, want 0 00 0 1 0 0",
                     out_vld, out_ai, full, empty, cnt, ovf);
        end
        checks++;
        if (stat !== '0) begin
            errors++;
            $display("FAIL reset_stat: got %h want 0", stat);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_first_push();
        step(1, 8'h03, 0, 0);
        checks++;
        if ({out_vld, out_ai, cnt, empty} !== {1'b1, 8'h03, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL first_push: vld=%b ai=%h cnt=%0d empty=%b, want 1 03 1 0",
                     out_vld, out_ai, cnt, empty);
        end
        step(0, 8'h00, 1, 0);
        checks++;
        if ({out_vld, empty, cnt} !== {1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL first_pop: vld=%b empty=%b cnt=%0d, want 0 1 0", out_vld, empty, cnt);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0);
        checks++;
        if ({full, cnt, ovf, out_ai} !== {1'b1, 4'd8, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL fill: full=%b cnt=%0d ovf=%b head=%h, want 1 8 0 00", full, cnt, ovf, out_ai);
        end
        step(1, 8'h08, 0, 0);
        checks++;
        if ({full, cnt, ovf, out_ai} !== {1'b1, 4'd8, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL drop: full=%b cnt=%0d ovf=%b head=%h, want 1 8 1 00", full, cnt, ovf, out_ai);
        end
        // Held head under back-pressure.
        step(0, 8'h00, 0, 0);
        checks++;
        if ({out_vld, out_ai} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL hold: vld=%b head=%h, want 1 00", out_vld, out_ai);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] want [8];
        for (int i = 0; i < 7; i++) want[i] = 8'(i + 1);
        want[7] = 8'h20;
        step(1, 8'h20, 1, 0);
        checks++;
        if ({cnt, ovf, full, out_ai} !== {4'd8, 1'b1, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL full_pushpop: cnt=%0d ovf=%b full=%b head=%h, want 8 1 1 01", cnt, ovf, full, out_ai);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_vld, out_ai} !== {1'b1, want[i]}) begin
                errors++;
                $display("FAIL drain[%0d]: vld=%b ai=%h, want 1 %h", i, out_vld, out_ai, want[i]);
            end
            step(0, 8'h00, 1, 0);
        end
        checks++;
        if ({empty, out_vld, ovf} !== {1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL drained: empty=%b vld=%b ovf=%b, want 1 0 1", empty, out_vld, ovf);
        end
    endtask

    task automatic test_stream();
        step(0, 8'h00, 0, 1);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b want 0", ovf);
        end
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h10 + i), 1, 0);
            checks++;
            if ({out_vld, out_ai, cnt, ovf} !== {1'b1, 8'(8'h10 + i), 4'd1, 1'b0}) begin
                errors++;
                $display("FAIL stream[%0d]: vld=%b ai=%h cnt=%0d ovf=%b, want 1 %h 1 0",
                         i, out_vld, out_ai, cnt, ovf, 8'(8'h10 + i));
            end
        end
        step(0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 31) == 0));
            checks++;
            if ({out_vld, out_ai} !== {(mq.size() > 0), exp_head()}) begin
                errors++;
                $display("FAIL rand_head[%0d]: vld=%b ai=%h, want %b %h", n, out_vld, out_ai,
                         (mq.size() > 0), exp_head());
            end
            checks++;
            if ({cnt, full, empty, ovf} !== {4'(mq.size()), (mq.size() == 8), (mq.size() == 0), m_ovf}) begin
                errors++;
                $display("FAIL rand_state[%0d]: cnt=%0d full=%b empty=%b ovf=%b, want %0d %b %b %b", n,
                         cnt, full, empty, ovf, mq.size(), (mq.size() == 8), (mq.size() == 0), m_ovf);
            end
            checks++;
            if (stat !== exp_stat()) begin
                errors++;
                $display("FAIL rand_stat[%0d]: got %h want %h", n, stat, exp_stat());
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 8'h00, 1, 0);
        while (mq.size() > 0) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
        checks++;
        if (cnt !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d want 5", cnt);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({out_vld, cnt, empty, ovf, out_ai} !== {1'b0, 4'd0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: vld=%b cnt=%0d empty=%b ovf=%b ai=%h, want 0 0 1 0 00",
                     out_vld, cnt, empty, ovf, out_ai);
        end
        #1 rst_n = 1;
        step(1, 8'h42, 0, 0);
        checks++;
        if ({out_vld, out_ai, cnt} !== {1'b1, 8'h42, 4'd1}) begin
            errors++;
            $display("FAIL post_reset_push: vld=%b ai=%h cnt=%0d, want 1 42 1", out_vld, out_ai, cnt);
        end
    endtask

    task automatic test_stat();
        logic [7:0] seq [5];
        md_stat_t want;
        seq[0] = 8'h00; seq[1] = 8'h08; seq[2] = 8'h10; seq[3] = 8'h18; seq[4] = 8'h19;
        step(0, 8'h00, 1, 1);
        while (mq.size() > 0) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step(1, seq[i], 1, 0);
`ifdef MD_WBUF_STAT_EN
        want = {16'd2, 16'd1, 16'd1, 16'd1};
`else
        want = '0;
`endif
        checks++;
        if (stat !== want || stat !== exp_stat()) begin
            errors++;
            $display("FAIL stat_count: got %h want %h", stat, want);
        end
        step(0, 8'h00, 1, 1);
        checks++;
        if (stat !== '0) begin
            errors++;
            $display("FAIL stat_clear: got %h want 0", stat);
        end
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_pushpop();
        test_stream();
        test_random();
        test_async_reset();
        test_stat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, want completion");
        $fatal(1);
    end

endmodule
